// File: rtl/ttt_move_sequencer.sv
// Tic-tac-toe turn controller: owns the board, validates player/computer moves,
// and evaluates win/draw/forfeit after each accepted move.

module ttt_line_chk (
  input  logic [5:0] cells,
  output logic       p_own,
  output logic       c_own
);
  assign p_own = (cells == 6'b010101);
  assign c_own = (cells == 6'b101010);
endmodule

module ttt_move_sequencer #(
  parameter int COMP_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        play,
  input  logic [3:0]  player_pos,
  input  logic        comp_valid,
  input  logic [3:0]  comp_pos,
  output logic [17:0] board,
  output logic        comp_req,
  output logic        player_turn,
  output logic        illegal_move,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count,
  output logic        timeout_flag
);
  localparam int NUM_LINES = 8;
  localparam int LC [NUM_LINES][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9},
                                       '{1,4,7}, '{2,5,8}, '{3,6,9},
                                       '{1,5,9}, '{3,5,7}};

  typedef enum logic [2:0] {IDLE, PLAYER_TURN, P_CHECK, COMP_TURN, C_CHECK, DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] pos;
  } mv_req_t;

  state_t                 state;
  logic [7:0]             to_cnt;
  logic [NUM_LINES-1:0]   p_line, c_line;
  logic                   p_win, c_win;
  mv_req_t                mv;
  logic [1:0]             mv_cell;
  logic                   mv_legal;
  logic [1:0]             mark;

  // One checker per winning line; both CHECK states share the results.
  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    ttt_line_chk u_chk (
      .cells ({board[2*LC[l][2]-2 +: 2], board[2*LC[l][1]-2 +: 2], board[2*LC[l][0]-2 +: 2]}),
      .p_own (p_line[l]),
      .c_own (c_line[l])
    );
  end

  assign p_win = |p_line;
  assign c_win = |c_line;

  // Only the side whose turn it is can present a move.
  always_comb begin
    mv = (state == PLAYER_TURN) ? '{vld: play, pos: player_pos}
                                : '{vld: comp_valid, pos: comp_pos};
    mv_cell = 2'b11;  // out-of-range positions look occupied
    for (int k = 1; k <= 9; k++)
      if (mv.pos == 4'(k)) mv_cell = board[2*k-2 +: 2];
  end

  assign mv_legal = (mv_cell == 2'b00);
  assign mark     = (state == PLAYER_TURN) ? 2'b01 : 2'b10;

  assign comp_req    = (state == COMP_TURN);
  assign player_turn = (state == PLAYER_TURN);
  assign game_over   = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      board        <= '0;
      illegal_move <= 1'b0;
      winner       <= 2'b00;
      move_count   <= 4'd0;
      timeout_flag <= 1'b0;
      to_cnt       <= 8'd0;
    end else begin
      illegal_move <= 1'b0;
      if (start) begin
        state        <= PLAYER_TURN;
        board        <= '0;
        winner       <= 2'b00;
        move_count   <= 4'd0;
        timeout_flag <= 1'b0;
        to_cnt       <= 8'd0;
      end else begin
        case (state)
          PLAYER_TURN: begin
            if (mv.vld && mv_legal) begin
              for (int k = 1; k <= 9; k++)
                if (mv.pos == 4'(k)) board[2*k-2 +: 2] <= mark;
              move_count <= move_count + 4'd1;
              state      <= P_CHECK;
            end else if (mv.vld) begin
              illegal_move <= 1'b1;
            end
          end
          COMP_TURN: begin
            if (mv.vld && mv_legal) begin
              for (int k = 1; k <= 9; k++)
                if (mv.pos == 4'(k)) board[2*k-2 +: 2] <= mark;
              move_count <= move_count + 4'd1;
              state      <= C_CHECK;
            end else begin
              illegal_move <= mv.vld;
              to_cnt       <= to_cnt + 8'd1;
              // Forfeit on the cycle the counter would reach the limit.
              if (to_cnt + 8'd1 == 8'(COMP_TIMEOUT)) begin
                timeout_flag <= 1'b1;
                winner       <= 2'b01;
                state        <= DONE;
              end
            end
          end
          P_CHECK: begin
            if (p_win) begin
              winner <= 2'b01;
              state  <= DONE;
            end else if (move_count == 4'd9) begin
              winner <= 2'b11;
              state  <= DONE;
            end else begin
              to_cnt <= 8'd0;
              state  <= COMP_TURN;
            end
          end
          C_CHECK: begin
            if (c_win) begin
              winner <= 2'b10;
              state  <= DONE;
            end else if (move_count == 4'd9) begin
              winner <= 2'b11;
              state  <= DONE;
            end else begin
              state  <= PLAYER_TURN;
            end
          end
          default: ;  // IDLE and DONE wait for start
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Directed bench for ttt_move_sequencer: wins, draw, illegal moves, forfeit, async reset.

module tb_ttt_move_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, play = 1'b0, comp_valid = 1'b0;
  logic [3:0]  player_pos = 4'd0, comp_pos = 4'd0;
  logic [17:0] board;
  logic        comp_req, player_turn, illegal_move, game_over, timeout_flag;
  logic [1:0]  winner;
  logic [3:0]  move_count;

  int n_chk = 0;
  int n_err = 0;

  ttt_move_sequencer #(.COMP_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .play(play),
    .player_pos(player_pos), .comp_valid(comp_valid), .comp_pos(comp_pos),
    .board(board), .comp_req(comp_req), .player_turn(player_turn),
    .illegal_move(illegal_move), .game_over(game_over), .winner(winner),
    .move_count(move_count), .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Strobe edge, then one more edge to leave the CHECK state.
  task automatic p_move(input logic [3:0] pos);
    play = 1'b1; player_pos = pos; tick(); play = 1'b0; tick();
  endtask

  task automatic c_move(input logic [3:0] pos);
    comp_valid = 1'b1; comp_pos = pos; tick(); comp_valid = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_board", board, 0);
    chk("rst_flags", {comp_req, player_turn, illegal_move, game_over, timeout_flag}, 0);
    chk("rst_winner", winner, 0);
    chk("rst_count", move_count, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("idle_pturn", player_turn, 0);

    // Player wins on the top row
    do_start();
    chk("start_pturn", player_turn, 1);
    play = 1'b1; player_pos = 4'd1; tick(); play = 1'b0;
    chk("p1_visible", board[1:0], 2'b01);
    tick();
    chk("comp_req_on", comp_req, 1);
    c_move(4); p_move(2); c_move(5);
    play = 1'b1; player_pos = 4'd3; tick(); play = 1'b0;
    chk("row_bits", board[5:0], 6'b010101);
    chk("not_over_yet", game_over, 0);
    tick();
    chk("pwin_over", game_over, 1);
    chk("pwin_winner", winner, 2'b01);
    chk("pwin_count", move_count, 5);
    chk("pwin_board", board, 18'h00295);
    play = 1'b1; player_pos = 4'd9; tick(); play = 1'b0;
    chk("done_frozen", board, 18'h00295);
    chk("done_no_illegal", illegal_move, 0);

    // Computer picks an occupied cell, then a free one
    do_start();
    chk("restart_board", board, 0);
    chk("restart_winner", winner, 0);
    chk("restart_over", game_over, 0);
    p_move(5);
    comp_valid = 1'b1; comp_pos = 4'd5; tick(); comp_valid = 1'b0;
    chk("c_illegal_pulse", illegal_move, 1);
    chk("c_illegal_req", comp_req, 1);
    chk("c_cell5_kept", board[9:8], 2'b01);
    tick();
    chk("c_illegal_end", illegal_move, 0);
    comp_valid = 1'b1; comp_pos = 4'd1; tick(); comp_valid = 1'b0;
    chk("c_cell1", board[1:0], 2'b10);
    chk("c_count", move_count, 2);
    tick();
    chk("back_to_player", player_turn, 1);

    // Out-of-range player positions; start beats a same-cycle play
    start = 1'b1; play = 1'b1; player_pos = 4'd5; tick(); start = 1'b0; play = 1'b0;
    chk("start_prio_board", board, 0);
    play = 1'b1; player_pos = 4'd0; tick(); play = 1'b0;
    chk("pos0_illegal", illegal_move, 1);
    tick();
    chk("pos0_pulse_end", illegal_move, 0);
    play = 1'b1; player_pos = 4'd12; tick(); play = 1'b0;
    chk("pos12_illegal", illegal_move, 1);
    chk("bad_count", move_count, 0);
    chk("bad_pturn", player_turn, 1);
    comp_valid = 1'b1; comp_pos = 4'd3; tick(); comp_valid = 1'b0;
    chk("comp_ignored_ill", illegal_move, 0);
    chk("comp_ignored_brd", board, 0);

    // Draw
    do_start();
    p_move(1); c_move(2); p_move(3); c_move(5); p_move(4);
    c_move(6); p_move(8); c_move(7); p_move(9);
    chk("draw_winner", winner, 2'b11);
    chk("draw_count", move_count, 9);
    chk("draw_over", game_over, 1);
    chk("draw_board", board, 18'h16A59);

    // Computer wins on the middle row
    do_start();
    p_move(1); c_move(4); p_move(2); c_move(5); p_move(9); c_move(6);
    chk("cwin_winner", winner, 2'b10);
    chk("cwin_over", game_over, 1);
    chk("cwin_count", move_count, 6);

    // Forfeit; an illegal attempt does not restart the counter
    do_start();
    p_move(1);
    tick();
    comp_valid = 1'b1; comp_pos = 4'd1; tick(); comp_valid = 1'b0;
    chk("to_illegal", illegal_move, 1);
    tick();
    chk("to_pending_req", comp_req, 1);
    chk("to_pending_flag", timeout_flag, 0);
    tick();
    chk("to_flag", timeout_flag, 1);
    chk("to_winner", winner, 2'b01);
    chk("to_over", game_over, 1);
    chk("to_req_off", comp_req, 0);

    // Legal move on the last allowed cycle beats the forfeit
    do_start();
    chk("to_cleared", timeout_flag, 0);
    p_move(1);
    tick(); tick(); tick();
    comp_valid = 1'b1; comp_pos = 4'd2; tick(); comp_valid = 1'b0;
    chk("late_move_cell", board[3:2], 2'b10);
    chk("late_move_noto", timeout_flag, 0);
    tick();
    chk("late_move_pturn", player_turn, 1);
    chk("late_move_winner", winner, 0);

    // Asynchronous reset mid-game with a computer strobe pending
    do_start();
    p_move(1);
    comp_valid = 1'b1; comp_pos = 4'd2;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_board", board, 0);
    chk("arst_req", comp_req, 0);
    chk("arst_count", move_count, 0);
    chk("arst_winner", winner, 0);
    comp_valid = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    chk("arst_idle", player_turn, 0);
    do_start();
    chk("arst_new_board", board, 0);
    chk("arst_new_pturn", player_turn, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
